// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with req/ack read-modify-write access, 64-bit counters and trap capture
module csr_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NUM_SCRATCH = 4,
    parameter int unsigned HART_ID     = 0,
    parameter int unsigned VENDOR_ID   = 0,
    parameter logic [31:0] MISA_VAL    = 32'h40000100
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            req_i,
    input  logic [1:0]      op_i,
    input  logic [11:0]     addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            ack_o,
    output logic            busy_o,
    output logic            illegal_o,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_val_i,
    input  logic            mret_i,
    input  logic            retire_i,
    input  logic            irq_timer_i,
    output logic            irq_en_o,
    output logic            irq_timer_en_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            tags_en_o,
    output logic            tags_if_en_o,
    output logic            tags_irq_clear_o
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RESP = 1'b1;
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam logic [11:0] A_MVENDOR  = 12'hF11;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
    localparam logic [11:0] A_MTAGS    = 12'h7C0;
    localparam logic [11:0] A_SCR0     = 12'h7C8;
    localparam logic [XLEN-1:0] ALIGN  = ~XLEN'(3);

    logic [0:0]      state_q, state_d;
    logic [1:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            mie_q, mie_d, mpie_q, mpie_d, mtie_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic            tags_en_q, tags_if_en_q, tags_clr_q;
    logic [XLEN-1:0] scratch_q [NUM_SCRATCH];
    logic            resp, legal, ro, commit;
    logic [XLEN-1:0] old_val, new_val;
    logic            we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause, we_mtval, we_tags;
    logic            we_cyc_lo, we_cyc_hi, we_ins_lo, we_ins_hi;

    assign resp        = (state_q == S_RESP);
    assign commit      = resp && legal && (op_q != 2'b00);
    assign new_val     = (op_q == 2'b01) ? wdata_q :
                         (op_q == 2'b10) ? (old_val | wdata_q) :
                         (op_q == 2'b11) ? (old_val & ~wdata_q) : old_val;
    assign we_mstatus  = commit && (addr_q == A_MSTATUS);
    assign we_mie      = commit && (addr_q == A_MIE);
    assign we_mtvec    = commit && (addr_q == A_MTVEC);
    assign we_mscratch = commit && (addr_q == A_MSCRATCH);
    assign we_mepc     = commit && (addr_q == A_MEPC);
    assign we_mcause   = commit && (addr_q == A_MCAUSE);
    assign we_mtval    = commit && (addr_q == A_MTVAL);
    assign we_tags     = commit && (addr_q == A_MTAGS);
    assign we_cyc_lo   = commit && (addr_q == A_MCYCLE);
    assign we_cyc_hi   = commit && (addr_q == A_MCYCLEH);
    assign we_ins_lo   = commit && (addr_q == A_MINSTRET);
    assign we_ins_hi   = commit && (addr_q == A_MINSTRH);

    assign rdata_o          = (resp && legal) ? old_val : '0;
    assign ack_o            = resp;
    assign busy_o           = resp;
    assign illegal_o        = resp && !legal;
    assign irq_en_o         = mie_q;
    assign irq_timer_en_o   = mtie_q;
    assign mtvec_o          = mtvec_q;
    assign mepc_o           = mepc_q;
    assign tags_en_o        = tags_en_q;
    assign tags_if_en_o     = tags_if_en_q;
    assign tags_irq_clear_o = tags_clr_q;

    // Address decode: current value of the latched CSR and whether the access is allowed
    always_comb begin
        old_val = '0;
        legal   = 1'b1;
        ro      = 1'b0;
        case (addr_q)
            A_MSTATUS:  old_val = XLEN'({mpie_q, 3'b000, mie_q, 3'b000});
            A_MISA:     old_val = XLEN'(MISA_VAL);
            A_MIE:      old_val = XLEN'({mtie_q, 7'd0});
            A_MTVEC:    old_val = mtvec_q;
            A_MSCRATCH: old_val = mscratch_q;
            A_MEPC:     old_val = mepc_q;
            A_MCAUSE:   old_val = mcause_q;
            A_MTVAL:    old_val = mtval_q;
            A_MIP:      begin old_val = XLEN'({irq_timer_i, 7'd0}); ro = 1'b1; end
            A_MCYCLE:   old_val = XLEN'(mcycle_q);
            A_MINSTRET: old_val = XLEN'(minstret_q);
            A_MCYCLEH:  begin old_val = XLEN'(mcycle_q[63:32]); legal = (XLEN == 32); end
            A_MINSTRH:  begin old_val = XLEN'(minstret_q[63:32]); legal = (XLEN == 32); end
            A_MVENDOR:  begin old_val = XLEN'(VENDOR_ID); ro = 1'b1; end
            A_MHARTID:  begin old_val = XLEN'(HART_ID); ro = 1'b1; end
            A_MTAGS:    old_val = XLEN'({tags_if_en_q, 1'b0, tags_en_q});
            default:    legal = 1'b0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++)
            if (addr_q == 12'(A_SCR0 + i)) begin
                old_val = scratch_q[i];
                legal   = 1'b1;
            end
        if (ro && op_q != 2'b00) legal = 1'b0;
    end

    // Next state: trap beats mret beats a CSR commit for the trap-owned registers; counter writes pause counting
    always_comb begin
        state_d    = (state_q == S_IDLE && req_i) ? S_RESP : S_IDLE;
        mie_d      = trap_i ? 1'b0 : mret_i ? mpie_q : we_mstatus ? new_val[3] : mie_q;
        mpie_d     = trap_i ? mie_q : mret_i ? 1'b1 : we_mstatus ? new_val[7] : mpie_q;
        mepc_d     = trap_i ? (trap_pc_i & ALIGN) : (we_mepc && !mret_i) ? (new_val & ALIGN) : mepc_q;
        mcause_d   = trap_i ? trap_cause_i : (we_mcause && !mret_i) ? new_val : mcause_q;
        mtval_d    = trap_i ? trap_val_i : (we_mtval && !mret_i) ? new_val : mtval_q;
        mcycle_d   = we_cyc_lo ? ((XLEN == 64) ? 64'(new_val) : {mcycle_q[63:32], new_val[31:0]}) :
                     we_cyc_hi ? {new_val[31:0], mcycle_q[31:0]} : mcycle_q + 64'd1;
        minstret_d = we_ins_lo ? ((XLEN == 64) ? 64'(new_val) : {minstret_q[63:32], new_val[31:0]}) :
                     we_ins_hi ? {new_val[31:0], minstret_q[31:0]} : minstret_q + {63'd0, retire_i};
    end

    // Access FSM and request latch
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_i) begin
                op_q    <= op_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
        end
    end

    // CSR storage, counters and the mtags clear pulse
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mie_q        <= 1'b0;
            mpie_q       <= 1'b0;
            mtie_q       <= 1'b0;
            mtvec_q      <= '0;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            mcycle_q     <= '0;
            minstret_q   <= '0;
            tags_en_q    <= 1'b0;
            tags_if_en_q <= 1'b0;
            tags_clr_q   <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            tags_clr_q <= we_tags && new_val[1];
            if (we_mie) mtie_q <= new_val[7];
            if (we_mtvec) mtvec_q <= new_val & ALIGN;
            if (we_mscratch) mscratch_q <= new_val;
            if (we_tags) begin
                tags_en_q    <= new_val[0];
                tags_if_en_q <= new_val[2];
            end
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (commit && addr_q == 12'(A_SCR0 + i)) scratch_q[i] <= new_val;
        end
    end
endmodule
